cfg_to_axis_seq: RTL and testbench
==================================

# cfg_to_axis_seq

Multi-channel successor to the single-field config tap. It extracts `NUM_CH` fields from the PS configuration bus and keeps a registered shadow copy of each. Any field whose value changes is queued and emitted as one AXI-Stream beat, tagged with its channel index on `M_AXIS_tdest`. The block sits between the PS config register bank and the RPSPMC stream consumers (DSP parameter loaders, FIFO controllers) that need change-triggered parameter updates with backpressure.

## Interface
- `NUM_CH`, 4: number of extracted channels (1..16).
- `SRC_ADDR`, 0: 32-bit word index of channel 0.
- `ADDR_STRIDE`, 1: word index step between channels.
- `SRC_BITS`, 32: MSB position + 1 of the field within its word.
- `DST_WIDTH`, 32: field width; the field spans bits `SRC_BITS-1` down to `SRC_BITS-DST_WIDTH` of the word.
- `CFG_WIDTH`, 1024: config bus width.
- `MAXIS_TDATA_WIDTH`, 32: stream width, ≥ `DST_WIDTH`.
- `SIGN_EXT`, 1: 1 = sign-extend the field into `tdata`; 0 = zero-extend.
- `REFRESH_CYCLES`, 1000000: refresh period; used only with the macro in Configuration.
- `a_clk` in 1: clock; all logic is on the rising edge.
- `a_rst` in 1: reset, synchronous, active-high.
- `cfg` in `CFG_WIDTH`: config bus, asynchronous to field semantics, registered once on entry.
- `M_AXIS_tdata` out `MAXIS_TDATA_WIDTH`: extended field value.
- `M_AXIS_tvalid` out 1: beat valid.
- `M_AXIS_tready` in 1: consumer ready.
- `M_AXIS_tdest` out `max(1,clog2(NUM_CH))`: channel index of the beat.
- `data` out `NUM_CH*DST_WIDTH`: flat shadow values, channel 0 in the LSBs.
- `pending` out `NUM_CH`: per-channel "queued, not yet loaded" flags.

## Operation
- Stage 1: `cfg_r <= cfg`.
- Stage 2, per channel i: `field_i = cfg_r[(SRC_ADDR+i*ADDR_STRIDE)*32+SRC_BITS-1 -: DST_WIDTH]`. If `field_i != shadow_i`, then `shadow_i <= field_i` and `pending[i] <= 1`.
- Coalescing: repeated changes while `pending[i]` is set produce one beat carrying the value current at load time.
- Output stage, 2 states:
  - IDLE: `tvalid` = 0. If any pending bit is set, load the next channel and go to VALID.
  - VALID: hold `tdata` and `tdest` stable. On `tvalid & tready`, load the next channel in the same cycle if one is pending and stay in VALID; otherwise go to IDLE.
- Load: `tdata <= ext(shadow_i)`, `tdest <= i`, `pending[i] <= 0`.
  - If a new change to channel i arrives in the load cycle, set wins: `pending[i]` stays 1 and the load takes the pre-update shadow value.
- Arbitration is round-robin. Start at `last_tdest+1` (mod `NUM_CH`) and pick the first pending channel.
- Reset values:
  - `shadow` = 0, `data` = 0, `cfg_r` = 0.
  - `tdata` = 0, `tdest` = 0, `tvalid` = 0.
  - `last_tdest` = `NUM_CH-1`.
  - `pending` = all ones, so every channel is emitted once after reset, in order 0..`NUM_CH-1`.
- Reset asserted mid-beat drops the beat: `tvalid` = 0 the next cycle, with no handshake required.

## Timing
- `cfg` change at edge n → `cfg_r` at n+1 → `shadow`/`pending` at n+2 → `tvalid`=1 at n+3, if the output stage is idle and no other channel is pending.
- With `tready` held high, throughput is one beat per cycle.
- `tvalid` never deasserts without a handshake, except on reset.
- `data` follows `shadow`: 2 cycles after a `cfg` change.
- `pending` is observable with the same timing as `shadow`.

## Configuration
- `CFG_TO_AXIS_SEQ_PERIODIC_EN`:
  - Defined: a free-running counter counts 0..`REFRESH_CYCLES-1`. On wrap it ORs all ones into `pending`, so every channel is re-emitted periodically even without changes. The counter resets to 0.
  - Undefined: no counter; beats are emitted only after reset and on field changes.

## Test plan
- Reset release with `NUM_CH`=4, `cfg`=0, `tready`=1 → 4 beats, `tdest` 0,1,2,3, `tdata`=0, first `tvalid` 1 cycle after reset deasserts; then `tvalid` stays 0.
- `DST_WIDTH`=16, `SRC_BITS`=32, `SIGN_EXT`=1: write word 2 = 0x8001_5555 → one beat, `tdest`=2, `tdata`=0xFFFF_8001, 3 cycles after the write. With `SIGN_EXT`=0 → `tdata`=0x0000_8001.
- `tready`=0 for 10 cycles while ch1 is written 0x11, 0x22, 0x33 → exactly one ch1 beat carrying 0x33; `tdata`/`tdest` stable until `tready`=1.
- Same-cycle writes to ch0 and ch3 with last `tdest`=1 → ch3 beat then ch0 beat, back-to-back.
- Reset asserted while `tvalid`=1 and `tready`=0 → `tvalid`=0 next cycle; after release, 4 beats with data 0 (shadow cleared).
- Macro defined, `REFRESH_CYCLES`=100, `cfg` static → a full 4-beat burst every 100 cycles. Macro undefined → no further beats after the initial burst.

Source files
------------

// File: rtl/cfg_to_axis_seq.sv
// Config-bus field shadows -> change-triggered AXI-Stream beats tagged by channel; cfg->tvalid 3 cycles, stalls hold beat.
// Optional periodic re-emit of all channels under CFG_TO_AXIS_SEQ_PERIODIC_EN (counter of REFRESH_CYCLES).
module cfg_to_axis_seq #(
  parameter int NUM_CH            = 4,
  parameter int SRC_ADDR          = 0,
  parameter int ADDR_STRIDE       = 1,
  parameter int SRC_BITS          = 32,
  parameter int DST_WIDTH         = 32,
  parameter int CFG_WIDTH         = 1024,
  parameter int MAXIS_TDATA_WIDTH = 32,
  parameter int SIGN_EXT          = 1,
  parameter int REFRESH_CYCLES    = 1000000,
  localparam int TDEST_W          = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic                          a_clk,
  input  logic                          a_rst,
  input  logic [CFG_WIDTH-1:0]          cfg,
  output logic [MAXIS_TDATA_WIDTH-1:0]  M_AXIS_tdata,
  output logic                          M_AXIS_tvalid,
  input  logic                          M_AXIS_tready,
  output logic [TDEST_W-1:0]            M_AXIS_tdest,
  output logic [NUM_CH*DST_WIDTH-1:0]   data,
  output logic [NUM_CH-1:0]             pending
);

  typedef enum logic {S_IDLE = 1'b0, S_VALID = 1'b1} state_t;

  localparam logic [TDEST_W-1:0] LAST_RST = TDEST_W'(NUM_CH - 1);

  logic [CFG_WIDTH-1:0]         cfg_q;
  logic [NUM_CH*DST_WIDTH-1:0]  shadow_q, shadow_d;
  logic [NUM_CH-1:0]            pending_q, pending_d, changed;
  logic [MAXIS_TDATA_WIDTH-1:0] tdata_q, tdata_d, pick_ext;
  logic [TDEST_W-1:0]           tdest_q, tdest_d, last_q, last_d, pick;
  logic [DST_WIDTH-1:0]         pick_val;
  logic                         any_pend, load, refresh;
  state_t                       state_q, state_d;

  // Only the field bits of the registered bus are consumed.
  logic unused_cfg;
  assign unused_cfg = ^cfg_q;

`ifdef CFG_TO_AXIS_SEQ_PERIODIC_EN
  localparam int CNT_W = (REFRESH_CYCLES > 1) ? $clog2(REFRESH_CYCLES) : 1;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  assign refresh = (cnt_q == CNT_W'(REFRESH_CYCLES - 1));
  assign cnt_d   = refresh ? '0 : cnt_q + CNT_W'(1);

  always_ff @(posedge a_clk) begin
    if (a_rst) cnt_q <= '0;
    else       cnt_q <= cnt_d;
  end
`else
  assign refresh = 1'b0;
`endif

  always_comb begin
    shadow_d = shadow_q;
    changed  = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      if (cfg_q[(SRC_ADDR + i*ADDR_STRIDE)*32 + SRC_BITS - 1 -: DST_WIDTH] !=
          shadow_q[i*DST_WIDTH +: DST_WIDTH]) begin
        changed[i] = 1'b1;
        shadow_d[i*DST_WIDTH +: DST_WIDTH] =
          cfg_q[(SRC_ADDR + i*ADDR_STRIDE)*32 + SRC_BITS - 1 -: DST_WIDTH];
      end
    end
  end

  // Round-robin: smallest distance from last_q+1 (mod NUM_CH) among pending channels.
  always_comb begin
    int best;
    int d;
    best     = NUM_CH;
    d        = 0;
    pick     = '0;
    pick_val = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      d = i - int'(last_q) - 1;
      if (d < 0) d = d + NUM_CH;
      if (pending_q[i] && (d < best)) begin
        best     = d;
        pick     = TDEST_W'(i);
        pick_val = shadow_q[i*DST_WIDTH +: DST_WIDTH];
      end
    end
  end

  assign any_pend = |pending_q;

  generate
    if (SIGN_EXT != 0) begin : g_sext
      assign pick_ext = MAXIS_TDATA_WIDTH'($signed(pick_val));
    end else begin : g_zext
      assign pick_ext = MAXIS_TDATA_WIDTH'(pick_val);
    end
  endgenerate

  // A change landing in the load cycle re-sets the bit: set wins over clear.
  always_comb begin
    pending_d = pending_q;
    for (int i = 0; i < NUM_CH; i++) begin
      if (load && (pick == TDEST_W'(i))) pending_d[i] = 1'b0;
    end
    pending_d = pending_d | changed;
    if (refresh) pending_d = '1;
  end

  always_ff @(posedge a_clk) begin
    if (a_rst) state_q <= S_IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE:  if (any_pend) state_d = S_VALID;
      S_VALID: if (M_AXIS_tready && !any_pend) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    M_AXIS_tvalid = (state_q == S_VALID);
    load          = any_pend && ((state_q == S_IDLE) || M_AXIS_tready);
  end

  always_comb begin
    tdata_d = tdata_q;
    tdest_d = tdest_q;
    last_d  = last_q;
    if (load) begin
      tdata_d = pick_ext;
      tdest_d = pick;
      last_d  = pick;
    end
  end

  always_ff @(posedge a_clk) begin
    if (a_rst) begin
      cfg_q     <= '0;
      shadow_q  <= '0;
      pending_q <= '1;
      tdata_q   <= '0;
      tdest_q   <= '0;
      last_q    <= LAST_RST;
    end else begin
      cfg_q     <= cfg;
      shadow_q  <= shadow_d;
      pending_q <= pending_d;
      tdata_q   <= tdata_d;
      tdest_q   <= tdest_d;
      last_q    <= last_d;
    end
  end

  assign M_AXIS_tdata = tdata_q;
  assign M_AXIS_tdest = tdest_q;
  assign data         = shadow_q;
  assign pending      = pending_q;

endmodule

// File: tb/tb_cfg_to_axis_seq.sv
// Directed bench for cfg_to_axis_seq: 4 channels, 16-bit fields in bits [31:16] of words 0..3.
// A second instance with zero extension shares all inputs.
module tb_cfg_to_axis_seq;

  localparam int NCH = 4;
  localparam int DW  = 16;
  localparam int TW  = 32;
  localparam int CW  = 128;

  logic              clk = 1'b0;
  logic              rst;
  logic              tready;
  logic [CW-1:0]     cfg;
  logic [TW-1:0]     tdata, z_tdata;
  logic              tvalid, z_tvalid;
  logic [1:0]        tdest, z_tdest;
  logic [NCH*DW-1:0] data, z_data;
  logic [NCH-1:0]    pending, z_pending;

  typedef struct packed {
    logic [1:0]  dest;
    logic [31:0] dat;
  } beat_t;

  beat_t exp_q[$];
  int    checks = 0;
  int    errors = 0;
  int    beats  = 0;
  int    b0;

  cfg_to_axis_seq #(
    .NUM_CH(NCH), .SRC_ADDR(0), .ADDR_STRIDE(1), .SRC_BITS(32), .DST_WIDTH(DW),
    .CFG_WIDTH(CW), .MAXIS_TDATA_WIDTH(TW), .SIGN_EXT(1), .REFRESH_CYCLES(100)
  ) dut (
    .a_clk(clk), .a_rst(rst), .cfg(cfg),
    .M_AXIS_tdata(tdata), .M_AXIS_tvalid(tvalid), .M_AXIS_tready(tready),
    .M_AXIS_tdest(tdest), .data(data), .pending(pending)
  );

  cfg_to_axis_seq #(
    .NUM_CH(NCH), .SRC_ADDR(0), .ADDR_STRIDE(1), .SRC_BITS(32), .DST_WIDTH(DW),
    .CFG_WIDTH(CW), .MAXIS_TDATA_WIDTH(TW), .SIGN_EXT(0), .REFRESH_CYCLES(100)
  ) dut_z (
    .a_clk(clk), .a_rst(rst), .cfg(cfg),
    .M_AXIS_tdata(z_tdata), .M_AXIS_tvalid(z_tvalid), .M_AXIS_tready(tready),
    .M_AXIS_tdest(z_tdest), .data(z_data), .pending(z_pending)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic push(input logic [1:0] d, input logic [31:0] v);
    beat_t b;
    b.dest = d;
    b.dat  = v;
    exp_q.push_back(b);
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic set_field(input int ch, input logic [15:0] v);
    cfg[ch*32 + 16 +: 16] = v;
  endtask

  task automatic wait_vld(input string tag);
    int n = 0;
    while (!tvalid && n < 20) begin
      tick(1);
      n++;
    end
    check({tag, "_vld"}, 64'(tvalid), 64'd1);
  endtask

  // Scoreboard: every handshake must match the oldest expected beat.
  always @(negedge clk) begin
    if (!rst && tvalid && tready) begin
      beat_t b;
      beats++;
      check("beat_expected", 64'(exp_q.size() != 0), 64'd1);
      if (exp_q.size() != 0) begin
        b = exp_q.pop_front();
        check("beat_tdest", 64'(tdest), 64'(b.dest));
        check("beat_tdata", 64'(tdata), 64'(b.dat));
      end
    end
  end

  initial begin
    rst    = 1'b1;
    tready = 1'b1;
    cfg    = '0;
    tick(3);
    check("rst_tvalid",  64'(tvalid),  64'd0);
    check("rst_tdata",   64'(tdata),   64'd0);
    check("rst_tdest",   64'(tdest),   64'd0);
    check("rst_pending", 64'(pending), 64'hF);
    check("rst_data",    64'(data),    64'd0);

    for (int i = 0; i < NCH; i++) push(2'(i), 32'h0);
    rst = 1'b0;
    tick(1);
    check("first_vld_after_rst", 64'(tvalid), 64'd1);
    check("first_tdest",         64'(tdest),  64'd0);
    tick(6);
    check("burst_drained",   64'(exp_q.size()), 64'd0);
    check("idle_after_burst", 64'(tvalid),      64'd0);

`ifdef CFG_TO_AXIS_SEQ_PERIODIC_EN
    for (int r = 0; r < 3; r++)
      for (int i = 0; i < NCH; i++) push(2'(i), 32'h0);
    tick(303);
    check("periodic_drained", 64'(exp_q.size()), 64'd0);
    check("periodic_beats",   64'(beats),        64'd16);
`else
    push(2'd2, 32'hFFFF_8001);
    cfg[2*32 +: 32] = 32'h8001_5555;
    tick(2);
    check("sign_pending_set", 64'(pending[2]),      64'd1);
    check("sign_data",        64'(data[2*DW +: DW]), 64'h8001);
    check("sign_not_yet_vld", 64'(tvalid),          64'd0);
    tick(1);
    check("sign_vld_3cyc",    64'(tvalid),   64'd1);
    check("sign_tdest",       64'(tdest),    64'd2);
    check("sign_tdata",       64'(tdata),    64'hFFFF_8001);
    check("zext_tdata",       64'(z_tdata),  64'h0000_8001);
    check("sign_pending_clr", 64'(pending[2]), 64'd0);
    tick(2);
    check("sign_drained", 64'(exp_q.size()), 64'd0);

    tready = 1'b0;
    push(2'd0, 32'h0000_1234);
    set_field(0, 16'h1234);
    wait_vld("stall");
    push(2'd1, 32'h0000_0033);
    set_field(1, 16'h0011);
    tick(2);
    set_field(1, 16'h0022);
    tick(2);
    set_field(1, 16'h0033);
    for (int k = 0; k < 6; k++) begin
      tick(1);
      check("stall_tdest", 64'(tdest), 64'd0);
      check("stall_tdata", 64'(tdata), 64'h1234);
    end
    check("coalesce_pending", 64'(pending[1]),      64'd1);
    check("coalesce_shadow",  64'(data[1*DW +: DW]), 64'h0033);
    tready = 1'b1;
    tick(4);
    check("coalesce_drained", 64'(exp_q.size()), 64'd0);
    check("coalesce_idle",    64'(tvalid),       64'd0);

    push(2'd3, 32'h0000_7FFF);
    push(2'd0, 32'h0000_00AA);
    set_field(0, 16'h00AA);
    set_field(3, 16'h7FFF);
    wait_vld("rr");
    check("rr_first_tdest", 64'(tdest), 64'd3);
    tick(1);
    check("rr_b2b_vld",      64'(tvalid), 64'd1);
    check("rr_second_tdest", 64'(tdest),  64'd0);
    tick(3);
    check("rr_drained", 64'(exp_q.size()), 64'd0);

    tready = 1'b0;
    set_field(2, 16'h4444);
    wait_vld("drop");
    rst = 1'b1;
    cfg = '0;
    tick(1);
    check("rst_drop_vld",     64'(tvalid),  64'd0);
    check("rst_drop_pending", 64'(pending), 64'hF);
    check("rst_drop_data",    64'(data),    64'd0);
    tick(1);
    for (int i = 0; i < NCH; i++) push(2'(i), 32'h0);
    tready = 1'b1;
    rst    = 1'b0;
    tick(1);
    check("rerst_first_vld",   64'(tvalid), 64'd1);
    check("rerst_first_tdest", 64'(tdest),  64'd0);
    tick(6);
    check("rerst_drained", 64'(exp_q.size()), 64'd0);

    b0 = beats;
    tick(250);
    check("quiet_beats", 64'(beats - b0), 64'd0);
    check("quiet_vld",   64'(tvalid),     64'd0);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
